// File: rtl/nco_clk_en_gen.sv
// nco_clk_en_gen: multi-channel NCO clock-enable generator with glitch-free runtime retuning.
// Optional NCO_CLK_EN_GEN_SYNC_EN adds a global sync input that zeroes every accumulator.
module nco_clk_en_gen #(
    parameter int N_CH = 4,
    parameter int ACC_W = 24,
    parameter logic [ACC_W-1:0] INC_DEFAULT = 24'h400000,
    parameter int LOCK_WRAPS = 2,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef NCO_CLK_EN_GEN_SYNC_EN
    input  logic             sync,
`endif
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [ACC_W-1:0] cfg_inc,
    input  logic [ACC_W-1:0] cfg_phase,
    output logic [N_CH-1:0]  strobe,
    output logic [N_CH-1:0]  square,
    output logic [N_CH-1:0]  locked
);
    localparam logic [3:0] LW = 4'(LOCK_WRAPS);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [ACC_W-1:0] acc_q, acc_d, inc_q, inc_d, sh_inc_q, sh_inc_d, sh_ph_q, sh_ph_d;
        logic [3:0]       wc_q, wc_d;
        logic             pend_q, pend_d, stb_q, stb_d, lck_q, lck_d, we, carry, apply;
        logic [ACC_W:0]   sum;
        always_comb begin
            we       = cfg_we && (32'(cfg_ch) == 32'(c));
            sum      = {1'b0, acc_q} + {1'b0, inc_q};
            carry    = sum[ACC_W];
            // a zero increment never wraps, so a pending config applies straight away
            apply    = pend_q && (carry || inc_q == '0);
            acc_d    = apply ? sh_ph_q : sum[ACC_W-1:0];
            inc_d    = apply ? sh_inc_q : inc_q;
            wc_d     = apply ? 4'd0 : (carry && !pend_q && wc_q != LW) ? wc_q + 4'd1 : wc_q;
            pend_d   = we || (pend_q && !apply);
            stb_d    = carry;
            sh_inc_d = we ? cfg_inc : sh_inc_q;
            sh_ph_d  = we ? cfg_phase : sh_ph_q;
`ifdef NCO_CLK_EN_GEN_SYNC_EN
            if (sync) begin
                acc_d  = '0;
                inc_d  = pend_q ? sh_inc_q : inc_q;
                wc_d   = 4'd0;
                pend_d = we;
                stb_d  = 1'b0;
            end
`endif
            lck_d    = (wc_d == LW) && (inc_d != '0) && !pend_d;
        end
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                acc_q    <= '0;
                inc_q    <= INC_DEFAULT;
                sh_inc_q <= '0;
                sh_ph_q  <= '0;
                wc_q     <= 4'd0;
                pend_q   <= 1'b0;
                stb_q    <= 1'b0;
                lck_q    <= 1'b0;
            end else begin
                acc_q    <= acc_d;
                inc_q    <= inc_d;
                sh_inc_q <= sh_inc_d;
                sh_ph_q  <= sh_ph_d;
                wc_q     <= wc_d;
                pend_q   <= pend_d;
                stb_q    <= stb_d;
                lck_q    <= lck_d;
            end
        end
        assign strobe[c] = stb_q;
        assign square[c] = acc_q[ACC_W-1];
        assign locked[c] = lck_q;
    end
endmodule

// File: tb/tb_nco_clk_en_gen.sv
// tb_nco_clk_en_gen: directed checks of rate, retune, lock, zero-inc, bad channel and reset.
module tb_nco_clk_en_gen;
    logic        clk, rst_n, cfg_we, we3;
    logic [1:0]  cfg_ch, ch3;
    logic [23:0] cfg_inc, cfg_phase, inc3, ph3;
    logic [3:0]  strobe, square, locked;
    logic [2:0]  strobe3, square3, locked3;
    logic [15:0] sv, qv, lv;
    int          k, n_tests, n_fail, bad;

    nco_clk_en_gen dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc),
        .cfg_phase(cfg_phase), .strobe(strobe), .square(square), .locked(locked)
    );

    nco_clk_en_gen #(.N_CH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_we(we3), .cfg_ch(ch3), .cfg_inc(inc3),
        .cfg_phase(ph3), .strobe(strobe3), .square(square3), .locked(locked3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic set_wr(input logic en, input logic [1:0] ch, input logic [23:0] inc, input logic [23:0] ph);
        cfg_we = en;
        cfg_ch = ch;
        cfg_inc = inc;
        cfg_phase = ph;
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        k = 0;
        rst_n = 1'b0;
        set_wr(1'b0, 2'd0, 24'h0, 24'h0);
        we3 = 1'b0;
        ch3 = 2'd3;
        inc3 = 24'h555555;
        ph3 = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_strobe", 32'(strobe), 32'h0);
        check("rst_square", 32'(square), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        rst_n = 1'b1;
        sv = '0; qv = '0; lv = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            sv[i] = strobe[0]; qv[i] = square[0]; lv[i] = locked[0];
        end
        check("def_strobe", 32'(sv[7:0]), 32'h88);
        check("def_square", 32'(qv[7:0]), 32'h66);
        check("def_lock", 32'(lv[7:0]), 32'h80);
        check("def_all_ch", 32'(strobe), 32'hF);
        // ch1 retune to 0x555555 mid-period
        step();
        set_wr(1'b1, 2'd1, 24'h555555, 24'h0);
        step();
        set_wr(1'b0, 2'd0, 24'h0, 24'h0);
        check("wr_lock_drop", 32'(locked), 32'hD);
        sv = '0; qv = '0; lv = '0;
        sv[0] = strobe[1]; lv[0] = locked[1]; qv[0] = strobe[0];
        for (int i = 1; i < 16; i++) begin
            step();
            sv[i] = strobe[1]; lv[i] = locked[1]; qv[i] = strobe[0];
        end
        check("ch1_strobe", 32'(sv), 32'h9244);
        check("ch1_lock", 32'(lv), 32'hFE00);
        check("ch0_undisturbed", 32'(qv), 32'h4444);
        // ch2 double write, last wins
        set_wr(1'b1, 2'd2, 24'h200000, 24'h0);
        step();
        set_wr(1'b1, 2'd2, 24'h800000, 24'h0);
        step();
        set_wr(1'b0, 2'd0, 24'h0, 24'h0);
        sv = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            sv[i] = strobe[2];
        end
        check("ch2_last_wins", 32'(sv[7:0]), 32'h55);
        // ch3 zero increment then restore
        step();
        set_wr(1'b1, 2'd3, 24'h0, 24'h0);
        step();
        set_wr(1'b0, 2'd0, 24'h0, 24'h0);
        sv = '0; lv = '0;
        for (int i = 0; i < 13; i++) begin
            step();
            sv[i] = strobe[3]; lv[i] = locked[3];
        end
        check("ch3_zero_strobe", 32'(sv), 32'h0004);
        check("ch3_zero_lock", 32'(lv), 32'h0);
        set_wr(1'b1, 2'd3, 24'h400000, 24'h0);
        step();
        set_wr(1'b0, 2'd0, 24'h0, 24'h0);
        sv = '0; lv = '0;
        for (int i = 0; i < 9; i++) begin
            step();
            sv[i] = strobe[3]; lv[i] = locked[3];
        end
        check("ch3_restore_strobe", 32'(sv), 32'h110);
        check("ch3_restore_lock", 32'(lv), 32'h100);
        // out-of-range channel on the 3-channel instance
        step();
        we3 = 1'b1;
        step();
        we3 = 1'b0;
        sv = '0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            sv[i] = (strobe3 == 3'b111);
            if (locked3 != 3'b111) bad++;
        end
        check("bad_ch_strobe", 32'(sv), 32'h222);
        check("bad_ch_lock", 32'(bad), 32'h0);
        // pending config on ch0 discarded by reset
        step();
        step();
        set_wr(1'b1, 2'd0, 24'h100000, 24'h123456);
        step();
        set_wr(1'b0, 2'd0, 24'h0, 24'h0);
        rst_n = 1'b0;
        step();
        step();
        check("rst2_strobe", 32'(strobe), 32'h0);
        check("rst2_square", 32'(square), 32'h0);
        check("rst2_locked", 32'(locked), 32'h0);
        rst_n = 1'b1;
        sv = '0; qv = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            sv[i] = strobe[0]; qv[i] = square[0];
        end
        check("rst2_ch0_strobe", 32'(sv[7:0]), 32'h88);
        check("rst2_ch0_square", 32'(qv[7:0]), 32'h66);
        check("rst2_all_strobe", 32'(strobe), 32'hF);
        check("rst2_all_lock", 32'(locked), 32'hF);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
